// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit:
// FSM encodings, func3 codes, byte masks and decode helpers.
package mem_access_unit_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] RW_LB  = 3'b000;
  localparam logic [2:0] RW_LH  = 3'b001;
  localparam logic [2:0] RW_LW  = 3'b010;
  localparam logic [2:0] RW_LBU = 3'b100;
  localparam logic [2:0] RW_LHU = 3'b101;
  localparam logic [2:0] RW_SB  = 3'b000;
  localparam logic [2:0] RW_SH  = 3'b001;
  localparam logic [2:0] RW_SW  = 3'b010;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Byte mask before shifting by the address offset.
  function automatic logic [3:0] base_mask(input logic [2:0] rw);
    logic [3:0] m;
    unique case (rw[1:0])
      2'b00:   m = MASK_B;
      2'b01:   m = MASK_H;
      default: m = MASK_W;
    endcase
    return m;
  endfunction

  // True when the access crosses a word boundary.
  function automatic logic two_beat(input logic [2:0] rw,
                                    input logic [1:0] off);
    logic t;
    unique case (rw[1:0])
      2'b01:   t = (off == 2'd3);
      2'b10:   t = (off != 2'd0);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Legality of a request presented in IDLE.
  function automatic logic is_legal(input logic rd,
                                    input logic wr,
                                    input logic [2:0] rw);
    logic ok;
    if (rd && wr)
      ok = 1'b0;
    else if (wr)
      ok = rw inside {RW_SB, RW_SH, RW_SW};
    else
      ok = rw inside {RW_LB, RW_LH, RW_LW, RW_LBU, RW_LHU};
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Lane alignment: byte enables and store data shifted over an
// 8-byte window, plus load extraction and sign/zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  rw_type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [5:0]  sh;
  logic [31:0] raw;

  assign sh = {offset_i, 3'b000};

  // Shift masks/data into place and extend the selected load bytes.
  always_comb begin
    be_o    = {4'b0000, base_mask(rw_type_i)} << offset_i;
    wdata_o = {32'd0, wdata_i} << sh;
    raw     = 32'(rdata_i >> sh);
    unique case (rw_type_i[1:0])
      2'b00:
        rdata_o = {{24{~rw_type_i[2] & raw[7]}}, raw[7:0]};
      2'b01:
        rdata_o = {{16{~rw_type_i[2] & raw[15]}}, raw[15:0]};
      default:
        rdata_o = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: word-wide req/ack bus beats, misaligned
// split into two beats, load extension, error and timeout flags.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MAX_WAIT  = 255,
  parameter int PENDING_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  rw_type_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [PENDING_W-1:0] WAIT_LIM = PENDING_W'(MAX_WAIT);

  logic [1:0]           state_q, state_d;
  logic                 we_q, we_d;
  logic [2:0]           rw_q, rw_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          lo_q, lo_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [PENDING_W-1:0] cnt_q, cnt_d;

  logic        req_any;
  logic        legal;
  logic        in_beat;
  logic        is_b1;
  logic        timeout;
  logic        split;
  logic [31:0] base;
  logic [7:0]  be8;
  logic [63:0] wd64;
  logic [63:0] rd64;
  logic [31:0] ext;

  assign req_any = mem_read_i | mem_write_i;
  assign legal   = is_legal(mem_read_i, mem_write_i, rw_type_i);
  assign is_b1   = (state_q == ST_BEAT1);
  assign in_beat = (state_q == ST_BEAT0) | is_b1;
  assign timeout = in_beat & (cnt_q == WAIT_LIM);
  assign split   = two_beat(rw_q, addr_q[1:0]);
  assign base    = {addr_q[31:2], 2'b00};
  assign rd64    = is_b1 ? {bus_rdata_i, lo_q}
                         : {32'd0, bus_rdata_i};

  mem_lane_align u_align (
    .rw_type_i (rw_q),
    .offset_i  (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (rd64),
    .be_o      (be8),
    .wdata_o   (wd64),
    .rdata_o   (ext)
  );

  // Bus drive: quiet outside beats and once a beat has timed out.
  always_comb begin
    bus_req_o   = in_beat & ~timeout;
    bus_we_o    = 1'b0;
    bus_addr_o  = 32'd0;
    bus_be_o    = 4'd0;
    bus_wdata_o = 32'd0;
    if (bus_req_o) begin
      bus_we_o    = we_q;
      bus_addr_o  = is_b1 ? base + 32'd4 : base;
      bus_be_o    = is_b1 ? be8[7:4] : be8[3:0];
      bus_wdata_o = is_b1 ? wd64[63:32] : wd64[31:0];
    end
  end

  assign stall_o = ((state_q == ST_IDLE) & req_any) | in_beat;
  assign done_o  = (state_q == ST_DONE);
  assign rdata_o = rdata_q;
  assign err_o   = ((state_q == ST_IDLE) & req_any & ~legal)
                 | timeout;

  // Next-state, request latch, wait counter and load capture.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          cnt_d = '0;
          if (!legal) begin
            state_d = ST_DONE;
            rdata_d = 32'd0;
          end else begin
            state_d = ST_BEAT0;
            we_d    = mem_write_i;
            rw_d    = rw_type_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
          end
        end
      end
      ST_BEAT0, ST_BEAT1: begin
        if (timeout) begin
          state_d = ST_DONE;
          rdata_d = 32'd0;
        end else if (bus_ack_i) begin
          cnt_d = '0;
          if (!is_b1 && split) begin
            state_d = ST_BEAT1;
            lo_d    = bus_rdata_i;
          end else begin
            state_d = ST_DONE;
            rdata_d = we_q ? 32'd0 : ext;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      rw_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level memory model and
// bus responder, directed cases then random accesses.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  rw_type_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int n_cmp = 0;
  int n_mis = 0;

  mem_access_unit #(.MAX_WAIT(4), .PENDING_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .rw_type_i(rw_type_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
    .err_o(err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem  [logic [31:0]];
  logic [7:0]  refm [logic [31:0]];
  logic [31:0] bl_addr[$];
  logic [31:0] bl_wdata[$];
  logic [3:0]  bl_be[$];
  logic        bl_we[$];

  int delay_max = 0;
  bit never_ack = 0;
  int wl = 0;
  bit armed = 0;

  function automatic logic [7:0] init_b(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] mem_b(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_b(a);
  endfunction

  function automatic logic [7:0] ref_b(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_b(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      mem[a + 32'(i)]  = v[8*i +: 8];
      refm[a + 32'(i)] = v[8*i +: 8];
    end
  endtask

  function automatic int size_of(input logic [2:0] rw);
    return (rw[1:0] == 2'b00) ? 1 : (rw[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Expected load value straight from the byte memory.
  function automatic logic [31:0] load_exp(input logic [2:0] rw,
                                           input logic [31:0] a);
    int sz = size_of(rw);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < sz; i++)
      v[8*i +: 8] = ref_b(a + 32'(i));
    if (!rw[2] && sz == 1 && v[7])  v[31:8]  = '1;
    if (!rw[2] && sz == 2 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus slave: random wait, then ack with memory data / apply write.
  initial begin
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'd0;
    forever begin
      @(negedge clk);
      if (rst || !bus_req_o) begin
        bus_ack_i = 1'b0;
        armed     = 0;
      end else begin
        if (!armed) begin
          wl    = never_ack ? 1000 : $urandom_range(delay_max, 0);
          armed = 1;
        end
        if (wl == 0) begin
          bus_ack_i = 1'b1;
          bus_rdata_i = {mem_b(bus_addr_o + 32'd3),
                         mem_b(bus_addr_o + 32'd2),
                         mem_b(bus_addr_o + 32'd1),
                         mem_b(bus_addr_o)};
          if (bus_we_o)
            for (int i = 0; i < 4; i++)
              if (bus_be_o[i])
                mem[bus_addr_o + 32'(i)] = bus_wdata_o[8*i +: 8];
          bl_addr.push_back(bus_addr_o);
          bl_be.push_back(bus_be_o);
          bl_we.push_back(bus_we_o);
          bl_wdata.push_back(bus_wdata_o);
          armed = 0;
        end else begin
          bus_ack_i = 1'b0;
          wl--;
        end
      end
    end
  end

  // One access; counts cycles from the request cycle (cycle 1).
  task automatic run(input logic rd, input logic wr,
                     input logic [2:0] rw, input logic [31:0] a,
                     input logic [31:0] wd,
                     output int done_c, output int err_c,
                     output int stall_n, output int req_n,
                     output logic [31:0] rdo);
    bl_addr.delete(); bl_be.delete();
    bl_we.delete(); bl_wdata.delete();
    done_c = 0; err_c = 0; stall_n = 0; req_n = 0; rdo = 32'd0;
    @(negedge clk);
    mem_read_i = rd; mem_write_i = wr;
    rw_type_i = rw; addr_i = a; wdata_i = wd;
    for (int c = 1; c <= 60 && done_c == 0; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (stall_o) stall_n++;
      if (bus_req_o) req_n++;
      if (err_o && err_c == 0) err_c = c;
      if (done_o) begin
        done_c = c;
        rdo = rdata_o;
        mem_read_i = 1'b0;
        mem_write_i = 1'b0;
      end
    end
    mem_read_i = 1'b0;
    mem_write_i = 1'b0;
    chk("done_seen", 32'(done_c != 0), 32'd1);
  endtask

  int dc, ec, sn, rn;
  logic [31:0] rv;

  initial begin
    logic [2:0]  lt [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  rw;
    logic [31:0] a, wd, b0;
    logic        rd, mok;
    int          sz, nb;

    rst = 1'b1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    rw_type_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req",   32'(bus_req_o), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_addr",  bus_addr_o, 32'd0);
    chk("rst_be",    32'(bus_be_o), 32'd0);
    chk("rst_wdata", bus_wdata_o, 32'd0);
    rst = 1'b0;

    // LW zero-wait
    delay_max = 0;
    preload(32'h100, 32'hDEADBEEF);
    run(1, 0, RW_LW, 32'h100, 32'd0, dc, ec, sn, rn, rv);
    chk("lw_done_cyc", 32'(dc), 32'd3);
    chk("lw_stall_n",  32'(sn), 32'd2);
    chk("lw_beats",    32'(bl_addr.size()), 32'd1);
    chk("lw_be",       32'(bl_be[0]), 32'hF);
    chk("lw_rdata",    rv, 32'hDEADBEEF);

    // LB / LBU at offset 3
    delay_max = 1;
    preload(32'h200, 32'h80FFFFFF);
    run(1, 0, RW_LB, 32'h203, 32'd0, dc, ec, sn, rn, rv);
    chk("lb_rdata", rv, 32'hFFFFFF80);
    run(1, 0, RW_LBU, 32'h203, 32'd0, dc, ec, sn, rn, rv);
    chk("lbu_rdata", rv, 32'h00000080);

    // Misaligned SW
    run(0, 1, RW_SW, 32'h102, 32'h11223344, dc, ec, sn, rn, rv);
    chk("sw_beats", 32'(bl_addr.size()), 32'd2);
    if (bl_addr.size() == 2) begin
      chk("sw_a0",  bl_addr[0], 32'h100);
      chk("sw_be0", 32'(bl_be[0]), 32'hC);
      chk("sw_wd0", bl_wdata[0], 32'h33440000);
      chk("sw_we0", 32'(bl_we[0]), 32'd1);
      chk("sw_a1",  bl_addr[1], 32'h104);
      chk("sw_be1", 32'(bl_be[1]), 32'h3);
      chk("sw_wd1", bl_wdata[1], 32'h00001122);
    end
    for (int i = 0; i < 4; i++)
      refm[32'h102 + 32'(i)] = 8'(32'h11223344 >> (8 * i));

    // Misaligned LH, then LH across the top of memory
    preload(32'h100, 32'hAA000000);
    preload(32'h104, 32'h000000BB);
    run(1, 0, RW_LH, 32'h103, 32'd0, dc, ec, sn, rn, rv);
    chk("lh_rdata", rv, 32'hFFFFBBAA);
    chk("lh_beats", 32'(bl_addr.size()), 32'd2);
    run(1, 0, RW_LH, 32'hFFFFFFFF, 32'd0, dc, ec, sn, rn, rv);
    chk("lh_wrap_beats", 32'(bl_addr.size()), 32'd2);
    if (bl_addr.size() == 2) begin
      chk("lh_wrap_a0", bl_addr[0], 32'hFFFFFFFC);
      chk("lh_wrap_a1", bl_addr[1], 32'h00000000);
    end
    chk("lh_wrap_rdata", rv, load_exp(RW_LH, 32'hFFFFFFFF));

    // Illegal: store with rw 100, and read+write together
    run(0, 1, 3'b100, 32'h40, 32'h5, dc, ec, sn, rn, rv);
    chk("ill_st_err", 32'(ec), 32'd1);
    chk("ill_st_done", 32'(dc), 32'd2);
    chk("ill_st_req", 32'(rn), 32'd0);
    run(1, 1, RW_LW, 32'h40, 32'h5, dc, ec, sn, rn, rv);
    chk("ill_rw_err", 32'(ec), 32'd1);
    chk("ill_rw_done", 32'(dc), 32'd2);
    chk("ill_rw_req", 32'(rn), 32'd0);
    chk("ill_rw_rdata", rv, 32'd0);

    // Timeout with MAX_WAIT=4
    never_ack = 1;
    run(1, 0, RW_LW, 32'h300, 32'd0, dc, ec, sn, rn, rv);
    chk("to_req_n", 32'(rn), 32'd4);
    chk("to_err_cyc", 32'(ec), 32'd6);
    chk("to_done_cyc", 32'(dc), 32'd7);
    chk("to_stall_n", 32'(sn), 32'd6);
    chk("to_beats", 32'(bl_addr.size()), 32'd0);

    // Reset in the middle of BEAT0
    @(negedge clk);
    mem_read_i = 1'b1; rw_type_i = RW_LW; addr_i = 32'h300;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_req_on", 32'(bus_req_o), 32'd1);
    rst = 1'b1; mem_read_i = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_req", 32'(bus_req_o), 32'd0);
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    rst = 1'b0;
    never_ack = 0;

    // Random legal accesses against the byte model
    delay_max = 2;
    for (int k = 0; k < 40; k++) begin
      rd = 1'($urandom_range(1, 0));
      rw = rd ? lt[$urandom_range(4, 0)] : 3'($urandom_range(2, 0));
      if (k % 4 == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(7, 0));
      else            a = $urandom & 32'h0000FFFF;
      wd = $urandom;
      sz = size_of(rw);
      nb = (32'(a[1:0]) + 32'(sz) > 4) ? 2 : 1;
      b0 = {a[31:2], 2'b00};
      run(rd, ~rd, rw, a, wd, dc, ec, sn, rn, rv);
      chk("rnd_err", 32'(ec), 32'd0);
      chk("rnd_beats", 32'(bl_addr.size()), 32'(nb));
      if (bl_addr.size() > 0) chk("rnd_a0", bl_addr[0], b0);
      if (bl_addr.size() > 1) chk("rnd_a1", bl_addr[1], b0 + 32'd4);
      if (rd) begin
        chk("rnd_load", rv, load_exp(rw, a));
      end else begin
        for (int i = 0; i < sz; i++)
          refm[a + 32'(i)] = wd[8*i +: 8];
        mok = 1'b1;
        for (int i = -1; i <= sz; i++)
          if (mem_b(a + 32'(i)) !== ref_b(a + 32'(i))) mok = 1'b0;
        chk("rnd_store_mem", 32'(mok), 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage that sits directly downstream of the main/ALU control decode in the RISC-V core.
- Consumes MemRead, MemWrite and RW_type (func3) from control, the ALU-computed effective address, and rs2 store data.
- Runs word-wide bus transactions with a req/ack handshake and stalls the core while a transaction is in flight.
- Splits misaligned accesses into two bus beats, extends load data per RW_type, and flags illegal accesses and bus timeouts.

Parameters:
- MAX_WAIT, 255, maximum cycles a beat waits for bus_ack_i before a timeout error is raised. Range 1..255.
- PENDING_W, 8, width of the wait counter. Must hold MAX_WAIT.

Ports:
- clk  in  1  core clock, single domain.
- rst  in  1  synchronous, active-high reset.
- mem_read_i  in  1  load request (MemRead).
- mem_write_i  in  1  store request (MemWrite).
- rw_type_i  in  3  func3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  32  effective byte address from the ALU.
- wdata_i  in  32  store data (rs2).
- stall_o  out  1  core must hold PC and all inputs while this is high.
- done_o  out  1  one-cycle pulse when an access completes.
- rdata_o  out  32  extended load data; valid while done_o is high.
- err_o  out  1  one-cycle pulse on an illegal access or a timeout.
- bus_req_o  out  1  beat request.
- bus_we_o  out  1  1 = write beat.
- bus_addr_o  out  32  word-aligned address; bits [1:0] are always 0.
- bus_be_o  out  4  byte enables, bit i selects byte lane i.
- bus_wdata_o  out  32  write data, lane-shifted.
- bus_ack_i  in  1  beat complete; sampled only while bus_req_o is high.
- bus_rdata_i  in  32  read data; valid in the cycle bus_ack_i is high.

Behaviour:
- States: IDLE, BEAT0, BEAT1, DONE.
- Reset (sync, active-high, at the clock edge): state goes to IDLE. bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, rdata_o, done_o and err_o all clear to 0. The wait counter clears to 0.
- Reset takes priority over every other event. A transaction in flight is abandoned, and bus_req_o is low from the first post-reset cycle.
- stall_o is combinational: (state==IDLE and (mem_read_i or mem_write_i)) or state in {BEAT0, BEAT1}. It is 0 in DONE, so the core advances on the edge that leaves DONE.

IDLE:
- If exactly one of mem_read_i/mem_write_i is high and the access is legal, latch op, rw_type, address and data, then go to BEAT0.
- Illegal accesses:
  - both mem_read_i and mem_write_i high;
  - a store with rw_type not in {000, 001, 010};
  - a load with rw_type in {011, 110, 111}.
- On an illegal access: no bus activity, err_o pulses for 1 cycle, then go to DONE (rdata_o = 0).

Beat split (offset = addr[1:0]):
- Two beats are needed when (H or HU) and offset==3, or W and offset!=0.
- Otherwise the access is a single beat.
- Beat0 address = addr & ~3. Beat1 address = beat0 address + 4; it wraps modulo 2^32 (0xFFFFFFFD word access uses 0xFFFFFFFC, then 0x00000000).
- Byte enables are computed over an 8-byte window, base mask shifted left by offset: B = 0001, H = 0011, W = 1111. Low nibble goes to beat0, high nibble to beat1.
- Store data is shifted left by 8*offset across 64 bits and split the same way.

BEAT0 / BEAT1:
- bus_req_o is high with address, be, we and wdata stable until bus_ack_i is sampled high.
- On ack, capture bus_rdata_i (for loads), then go to the next beat or to DONE.
- The wait counter increments each cycle without ack. When it reaches MAX_WAIT, err_o pulses, the access is dropped and the state goes to DONE.
- The counter reloads to 0 for each beat.
- Zero-wait ack (ack in the first req cycle) is legal. Minimum latency from request to done_o is 3 cycles for a single beat and 4 for two.

DONE:
- done_o = 1. Go to IDLE unconditionally, so the same instruction is never re-issued.

Load data:
- Form the 64-bit {beat1, beat0} value, right-shift it by 8*offset, then extend.
- B and H sign-extend; BU and HU zero-extend; W is passed through.

Decomposition:
- Shared define file: FSM state encodings, RW_type codes (LB/LH/LW/LBU/LHU, SB/SH/SW), and base byte masks.
- One sub-module, mem_lane_align: combinational byte-enable/store-data shifter plus load extractor/extender, reused by both beats.

Test Plan:
- LW at 0x100, ack on the first req cycle, rdata 0xDEADBEEF -> one beat, be=1111, done_o on the 3rd cycle, rdata_o=0xDEADBEEF, stall_o high for exactly 2 cycles.
- LB at 0x203 with rdata 0x80FFFFFF -> rdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
- SW 0x11223344 at 0x102 -> beat0 addr 0x100, be=1100, wdata 0x33440000; beat1 addr 0x104, be=0011, wdata 0x00001122.
- LH at 0x103 with beat0=0xAA000000 and beat1=0x000000BB -> rdata_o=0xFFFFBBAA; address 0xFFFFFFFF -> beat1 addr 0x00000000.
- Store with rw_type 100, or mem_read_i and mem_write_i both high -> err_o pulse, bus_req_o never asserted, done_o the next cycle.
- MAX_WAIT=4 with ack never given -> err_o after 4 wait cycles, back to IDLE; a second run asserts rst mid-BEAT0 -> bus_req_o=0 on the next cycle, state IDLE.
